// File: rtl/video_pkg.sv
// Shared video stream types and default geometry.
// Used by the frame aligner, the stream selector and downstream timing blocks.
// Contents: video beat struct, aligner state enum, default 640x480x24 geometry.
package video_pkg;

   localparam int VID_DATA_W   = 24;
   localparam int VID_H_ACTIVE = 640;
   localparam int VID_V_ACTIVE = 480;

   typedef struct packed {
      logic [VID_DATA_W-1:0] data;
      logic                  last;   // end of line
      logic                  user;   // start of frame
   } beat_t;

   typedef enum logic [2:0] {
      SEEK  = 3'd0,
      PASS  = 3'd1,
      PAD   = 3'd2,
      DROP  = 3'd3,
      FLUSH = 3'd4
   } state_e;

endpackage

// File: rtl/video_frame_aligner_if.sv
// AXI4-Stream video bundle: 24-bit pixel, valid/ready, tlast = end of line, tuser = start of frame.
// master drives data/valid/last/user and samples ready; slave is the mirror image.
// Ports: tdata, tvalid, tready, tlast, tuser.
interface video_frame_aligner_if #(
   parameter int DATA_W = 24
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;
   logic              tuser;

   modport master (output tdata, output tvalid, output tlast, output tuser, input  tready);
   modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser, output tready);
endinterface

// File: rtl/video_frame_aligner_out_reg.sv
// Single-entry valid/ready output register (skid-free pipeline stage).
// Latency: 1 cycle from in handshake to out_vld_o.
// Backpressure: in_rdy_o = empty or downstream ready; data/valid hold while out_rdy_i=0.
module axis_out_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_dat_i,
   input  logic         in_vld_i,
   output logic         in_rdy_o,
   output logic [W-1:0] out_dat_o,
   output logic         out_vld_o,
   input  logic         out_rdy_i
);
   logic [W-1:0] dat_q;
   logic         vld_q;

   assign in_rdy_o  = !vld_q || out_rdy_i;
   assign out_dat_o = dat_q;
   assign out_vld_o = vld_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         dat_q <= '0;
         vld_q <= 1'b0;
      end else if (in_rdy_o) begin
         vld_q <= in_vld_i;
         if (in_vld_i) dat_q <= in_dat_i;
      end
   end
endmodule

// File: rtl/video_frame_aligner.sv
// Frame aligner: forces every output frame to H_ACTIVE x V_ACTIVE by padding, truncating or flushing.
// Latency: 1 cycle (single output register); tuser/tlast regenerated from the output position.
// Backpressure: input stalled in PAD/FLUSH and while the output register is full in PASS.
// Ports: clk/rst, s_axis_video (slave in), m_axis_video (master out), frame_done, err_short/long/abort pulses, err_count.
module video_frame_aligner
   import video_pkg::*;
#(
   parameter int                DATA_W   = VID_DATA_W,
   parameter int                H_ACTIVE = VID_H_ACTIVE,
   parameter int                V_ACTIVE = VID_V_ACTIVE,
   parameter logic [DATA_W-1:0] FILL     = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   video_frame_aligner_if.slave  s_axis_video,
   video_frame_aligner_if.master m_axis_video,
   output logic                  frame_done,
   output logic                  err_short,
   output logic                  err_long,
   output logic                  err_abort,
   output logic [15:0]           err_count
);
   localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

   state_e            state_q, state_d;
   logic [XW-1:0]     x_q, x_d;
   logic [YW-1:0]     y_q, y_d;
   logic              eof_q;
   logic              err_short_q, err_long_q, err_abort_q;
   logic              short_d, long_d, abort_d;
   logic [15:0]       err_cnt_q;

   logic              push, push_rdy, s_rdy;
   logic [DATA_W-1:0] push_dat;
   logic              at_origin, at_xlast, at_eof;
   logic [DATA_W+1:0] out_dat;
   logic              out_vld;

   assign at_origin = (x_q == '0) && (y_q == '0);
   assign at_xlast  = (x_q == X_LAST);
   assign at_eof    = at_xlast && (y_q == Y_LAST);

   always_comb begin
      state_d  = state_q;
      push     = 1'b0;
      push_dat = FILL;
      s_rdy    = 1'b0;
      short_d  = 1'b0;
      long_d   = 1'b0;
      abort_d  = 1'b0;
      case (state_q)
         SEEK: begin
            // A start-of-frame beat is only taken when it can be emitted at once,
            // otherwise it would be discarded like the junk before it.
            s_rdy = push_rdy || !s_axis_video.tuser;
            if (s_axis_video.tvalid && s_axis_video.tuser && push_rdy) begin
               push     = 1'b1;
               push_dat = s_axis_video.tdata;
               state_d  = PASS;
            end
         end
         PASS: begin
            if (s_axis_video.tvalid && s_axis_video.tuser && !at_origin) begin
               // New frame mid-frame: leave it pending and fill out the broken frame.
               abort_d = 1'b1;
               state_d = FLUSH;
            end else begin
               s_rdy = push_rdy;
               if (s_axis_video.tvalid && push_rdy) begin
                  if (at_origin && !s_axis_video.tuser) begin
                     state_d = SEEK;  // surplus lines after a complete frame
                  end else begin
                     push     = 1'b1;
                     push_dat = s_axis_video.tdata;
                     if (s_axis_video.tlast && !at_xlast) begin
                        short_d = 1'b1;
                        state_d = PAD;
                     end else if (at_xlast && !s_axis_video.tlast) begin
                        long_d  = 1'b1;
                        state_d = DROP;
                     end
                  end
               end
            end
         end
         PAD: begin
            if (push_rdy) begin
               push = 1'b1;
               if (at_xlast) state_d = PASS;
            end
         end
         DROP: begin
            s_rdy = !s_axis_video.tuser;
            if (s_axis_video.tvalid && s_axis_video.tuser) begin
               // At the frame origin the overlong line was the last one: nothing to flush.
               if (at_origin) begin
                  state_d = PASS;
               end else begin
                  abort_d = 1'b1;
                  state_d = FLUSH;
               end
            end else if (s_axis_video.tvalid && s_axis_video.tlast) begin
               state_d = PASS;
            end
         end
         FLUSH: begin
            if (push_rdy) begin
               push = 1'b1;
               if (at_eof) state_d = PASS;
            end
         end
         default: state_d = SEEK;
      endcase
   end

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (push) begin
         if (at_xlast) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
         end else begin
            x_d = x_q + XW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SEEK;
         x_q         <= '0;
         y_q         <= '0;
         eof_q       <= 1'b0;
         err_short_q <= 1'b0;
         err_long_q  <= 1'b0;
         err_abort_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         err_short_q <= short_d;
         err_long_q  <= long_d;
         err_abort_q <= abort_d;
         if (push) eof_q <= at_eof;
         if ((short_d || long_d || abort_d) && (err_cnt_q != 16'hFFFF))
            err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   axis_out_reg #(.W(DATA_W + 2)) u_out_reg (
      .clk       (clk),
      .rst       (rst),
      .in_dat_i  ({push_dat, at_xlast, at_origin}),
      .in_vld_i  (push),
      .in_rdy_o  (push_rdy),
      .out_dat_o (out_dat),
      .out_vld_o (out_vld),
      .out_rdy_i (m_axis_video.tready)
   );

   assign m_axis_video.tdata  = out_dat[DATA_W+1:2];
   assign m_axis_video.tlast  = out_dat[1];
   assign m_axis_video.tuser  = out_dat[0];
   assign m_axis_video.tvalid = out_vld;
   assign s_axis_video.tready = s_rdy && !rst;

   assign frame_done = out_vld && m_axis_video.tready && eof_q && !rst;
   assign err_short  = err_short_q;
   assign err_long   = err_long_q;
   assign err_abort  = err_abort_q;
   assign err_count  = err_cnt_q;
endmodule

// File: tb/tb_video_frame_aligner.sv
module tb_video_frame_aligner;
   localparam int H  = 8;
   localparam int V  = 4;
   localparam int FP = H * V;
   localparam logic [23:0] FILLV = 24'h000000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   video_frame_aligner_if #(.DATA_W(24)) s_if ();
   video_frame_aligner_if #(.DATA_W(24)) m_if ();
   logic        frame_done, err_short, err_long, err_abort;
   logic [15:0] err_count;

   video_frame_aligner #(.DATA_W(24), .H_ACTIVE(H), .V_ACTIVE(V), .FILL(FILLV)) dut (
      .clk          (clk),
      .rst          (rst),
      .s_axis_video (s_if),
      .m_axis_video (m_if),
      .frame_done   (frame_done),
      .err_short    (err_short),
      .err_long     (err_long),
      .err_abort    (err_abort),
      .err_count    (err_count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model: the expected output pixel sequence; tuser/tlast/frame_done follow
   // purely from the index of the beat in the output stream.
   logic [23:0] exp_q[$];
   int out_idx = 0, outs_seen = 0, fill_seen = 0, fd_cnt = 0;
   int short_cnt = 0, long_cnt = 0, abort_cnt = 0;
   bit rand_rdy = 1'b0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endfunction

   function automatic logic [23:0] pix(input logic [7:0] tag, input int ln, input int p);
      return {tag, 8'(ln), 8'(p + 1)};
   endfunction

   // Downstream ready: always 1, or a coin flip each cycle.
   initial begin
      m_if.tready = 1'b1;
      forever begin
         @(negedge clk);
         m_if.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Compare process: one sample per cycle, well away from the rising edge.
   initial begin
      bit          prev_stall = 1'b0;
      logic [23:0] prev_dat   = '0;
      logic [23:0] e;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall)
               check("hold_stable", {39'd0, m_if.tvalid, m_if.tdata}, {39'd0, 1'b1, prev_dat});
            if (err_short) short_cnt++;
            if (err_long)  long_cnt++;
            if (err_abort) abort_cnt++;
            if (m_if.tvalid && m_if.tready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL extra_beat: got data 0x%0h, required no beat", m_if.tdata);
               end else begin
                  e = exp_q.pop_front();
                  check("tdata", 64'(m_if.tdata), 64'(e));
                  check("tuser", 64'(m_if.tuser), 64'((out_idx % FP) == 0));
                  check("tlast", 64'(m_if.tlast), 64'((out_idx % H) == H - 1));
                  check("frame_done", 64'(frame_done), 64'((out_idx % FP) == FP - 1));
               end
               out_idx++;
               outs_seen++;
               if (m_if.tdata == FILLV) fill_seen++;
               if (frame_done) fd_cnt++;
            end else begin
               check("frame_done_idle", 64'(frame_done), 64'd0);
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_dat   = m_if.tdata;
         end
      end
   end

   // Present one beat from a falling edge; returns at the falling edge after acceptance.
   task automatic send(input logic [23:0] d, input logic u, input logic l, output int stalls);
      stalls      = 0;
      s_if.tdata  = d;
      s_if.tuser  = u;
      s_if.tlast  = l;
      s_if.tvalid = 1'b1;
      #1;
      while (!s_if.tready && stalls < 500) begin
         @(negedge clk);
         #1;
         stalls++;
      end
      if (!s_if.tready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: tready=0 after 500 cycles, required 1");
      end
      @(negedge clk);
      s_if.tvalid = 1'b0;
   endtask

   task automatic send_line(input logic [7:0] tag, input int ln, input int npix, input bit sof);
      int st;
      for (int p = 0; p < npix; p++) send(pix(tag, ln, p), sof && (p == 0), p == npix - 1, st);
   endtask

   // ndata real pixels then FILL up to the line width
   task automatic expect_line(input logic [7:0] tag, input int ln, input int ndata);
      for (int p = 0; p < H; p++) exp_q.push_back((p < ndata) ? pix(tag, ln, p) : FILLV);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || m_if.tvalid) && n < 400) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({name, "_left_in_model"}, 64'(exp_q.size()), 64'd0);
      @(negedge clk);
   endtask

   initial begin
      int st, o0, f0, fd0, e0;
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tuser  = 1'b0;
      s_if.tlast  = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
      check("rst_m_tdata", 64'(m_if.tdata), 64'd0);
      check("rst_s_tready", 64'(s_if.tready), 64'd0);
      check("rst_err_count", 64'(err_count), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("seek_tready", 64'(s_if.tready), 64'd1);
      @(negedge clk);

      // 1: clean frame, 1-cycle latency
      o0 = outs_seen; fd0 = fd_cnt;
      for (int l = 0; l < V; l++) expect_line(8'h11, l, H);
      send(pix(8'h11, 0, 0), 1'b1, 1'b0, st);
      #1;
      check("latency_tvalid", 64'(m_if.tvalid), 64'd1);
      check("latency_tdata", 64'(m_if.tdata), 64'h110001);
      for (int p = 1; p < H; p++) send(pix(8'h11, 0, p), 1'b0, p == H - 1, st);
      for (int l = 1; l < V; l++) send_line(8'h11, l, H, 1'b0);
      drain("clean");
      check("clean_outs", 64'(outs_seen - o0), 64'd32);
      check("clean_frame_done", 64'(fd_cnt - fd0), 64'd1);
      check("clean_err_count", 64'(err_count), 64'd0);

      // 2: line 1 ends after 5 pixels -> padded
      o0 = outs_seen; f0 = fill_seen; e0 = short_cnt;
      expect_line(8'h22, 0, H); expect_line(8'h22, 1, 5);
      expect_line(8'h22, 2, H); expect_line(8'h22, 3, H);
      send_line(8'h22, 0, H, 1'b1);
      send_line(8'h22, 1, 5, 1'b0);
      send_line(8'h22, 2, H, 1'b0);
      send_line(8'h22, 3, H, 1'b0);
      drain("short");
      check("short_outs", 64'(outs_seen - o0), 64'd32);
      check("short_fills", 64'(fill_seen - f0), 64'd3);
      check("short_pulses", 64'(short_cnt - e0), 64'd1);
      check("short_err_count", 64'(err_count), 64'd1);

      // 3: line 2 carries 11 pixels -> truncated to 8
      o0 = outs_seen; e0 = long_cnt;
      expect_line(8'h33, 0, H); expect_line(8'h33, 1, H);
      expect_line(8'h33, 2, H); expect_line(8'h33, 3, H);
      send_line(8'h33, 0, H, 1'b1);
      send_line(8'h33, 1, H, 1'b0);
      send_line(8'h33, 2, 11, 1'b0);
      send_line(8'h33, 3, H, 1'b0);
      drain("long");
      check("long_outs", 64'(outs_seen - o0), 64'd32);
      check("long_pulses", 64'(long_cnt - e0), 64'd1);
      check("long_err_count", 64'(err_count), 64'd2);

      // 4: new frame at (x=3,y=2) -> 13 FILL, then the held beat opens the next frame
      o0 = outs_seen; f0 = fill_seen; fd0 = fd_cnt; e0 = abort_cnt;
      expect_line(8'h44, 0, H); expect_line(8'h44, 1, H);
      expect_line(8'h44, 2, 3); expect_line(8'h44, 3, 0);
      for (int l = 0; l < V; l++) expect_line(8'h55, l, H);
      send_line(8'h44, 0, H, 1'b1);
      send_line(8'h44, 1, H, 1'b0);
      for (int p = 0; p < 3; p++) send(pix(8'h44, 2, p), 1'b0, 1'b0, st);
      send(pix(8'h55, 0, 0), 1'b1, 1'b0, st);
      check("abort_stall_cycles", 64'(st), 64'd14);
      for (int p = 1; p < H; p++) send(pix(8'h55, 0, p), 1'b0, p == H - 1, st);
      for (int l = 1; l < V; l++) send_line(8'h55, l, H, 1'b0);
      drain("abort");
      check("abort_outs", 64'(outs_seen - o0), 64'd64);
      check("abort_fills", 64'(fill_seen - f0), 64'd13);
      check("abort_frame_done", 64'(fd_cnt - fd0), 64'd2);
      check("abort_pulses", 64'(abort_cnt - e0), 64'd1);
      check("abort_err_count", 64'(err_count), 64'd3);

      // 5: clean frame under random downstream backpressure
      o0 = outs_seen; fd0 = fd_cnt;
      rand_rdy = 1'b1;
      for (int l = 0; l < V; l++) expect_line(8'h66, l, H);
      for (int l = 0; l < V; l++) send_line(8'h66, l, H, l == 0);
      drain("bp");
      rand_rdy = 1'b0;
      @(negedge clk);
      check("bp_outs", 64'(outs_seen - o0), 64'd32);
      check("bp_frame_done", 64'(fd_cnt - fd0), 64'd1);
      check("bp_err_count", 64'(err_count), 64'd3);

      // 6: one-cycle reset while padding, then headless stream is dropped
      expect_line(8'h77, 0, H);
      exp_q.push_back(pix(8'h77, 1, 0));
      exp_q.push_back(pix(8'h77, 1, 1));
      send_line(8'h77, 0, H, 1'b1);
      send_line(8'h77, 1, 2, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      #1;
      exp_q.delete();
      out_idx = 0;
      check("rstpad_m_tvalid", 64'(m_if.tvalid), 64'd0);
      check("rstpad_m_tdata", 64'(m_if.tdata), 64'd0);
      check("rstpad_m_tuser", 64'(m_if.tuser), 64'd0);
      check("rstpad_m_tlast", 64'(m_if.tlast), 64'd0);
      check("rstpad_s_tready", 64'(s_if.tready), 64'd0);
      check("rstpad_pulses", 64'({frame_done, err_short, err_long, err_abort}), 64'd0);
      check("rstpad_err_count", 64'(err_count), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("rstpad_seek_tready", 64'(s_if.tready), 64'd1);
      @(negedge clk);
      o0 = outs_seen; fd0 = fd_cnt;
      for (int p = 0; p < 5; p++) send(pix(8'h88, 0, p), 1'b0, p == 2, st);
      repeat (3) @(negedge clk);
      check("seek_drop_outs", 64'(outs_seen - o0), 64'd0);
      for (int l = 0; l < V; l++) expect_line(8'h99, l, H);
      for (int l = 0; l < V; l++) send_line(8'h99, l, H, l == 0);
      drain("resync");
      check("resync_outs", 64'(outs_seen - o0), 64'd32);
      check("resync_frame_done", 64'(fd_cnt - fd0), 64'd1);
      check("resync_err_count", 64'(err_count), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached, required test completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1);
   end
endmodule
